// File: rtl/rps_match_scoreboard_if.sv
// Round-FSM observation inputs and scoreboard outputs for the rock-paper-scissors match scoreboard.
interface rps_match_scoreboard_if #(
  parameter int unsigned CNT_W = 4
);
  logic [2:0]       game_state;
  logic [1:0]       round_winner;
  logic             new_match;
  logic [CNT_W-1:0] p1_score;
  logic [CNT_W-1:0] p2_score;
  logic [CNT_W-1:0] tie_count;
  logic [CNT_W-1:0] invalid_count;
  logic [CNT_W-1:0] round_count;
  logic             match_over;
  logic             match_done;
  logic [1:0]       match_winner;

  modport master (
    output game_state, round_winner, new_match,
    input  p1_score, p2_score, tie_count, invalid_count, round_count,
           match_over, match_done, match_winner
  );

  modport slave (
    input  game_state, round_winner, new_match,
    output p1_score, p2_score, tie_count, invalid_count, round_count,
           match_over, match_done, match_winner
  );
endinterface

// File: rtl/rps_match_scoreboard.sv
// Match scoreboard: counts completed rounds from the round FSM and declares a
// first-to-N winner, or a draw once the round cap is reached.
module rps_match_scoreboard #(
  parameter int unsigned WINS_TO_TAKE = 3,
  parameter int unsigned MAX_ROUNDS   = 9,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  rps_match_scoreboard_if.slave  bus
);

  localparam logic [2:0]       GS_RESULT = 3'b010;
  localparam logic [CNT_W-1:0] WINS      = CNT_W'(WINS_TO_TAKE);
  localparam logic [CNT_W-1:0] MAXR      = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [0:0] {PLAY, DONE} state_t;

  state_t           state, next_state;
  logic [2:0]       prev_state;
  logic [CNT_W-1:0] p1, p2, ties, inv, rc;
  logic [CNT_W-1:0] p1_n, p2_n, ties_n, inv_n, rc_n;
  logic [1:0]       winner, winner_n;
  logic             done, done_n;
  logic             round_event_c;

  // One event per RESULT entry, regardless of how long RESULT is held.
  assign round_event_c = (bus.game_state == GS_RESULT) && (prev_state != GS_RESULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PLAY;
      prev_state <= 3'b000;
      p1         <= '0;
      p2         <= '0;
      ties       <= '0;
      inv        <= '0;
      rc         <= '0;
      winner     <= 2'b00;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      prev_state <= bus.game_state;
      p1         <= p1_n;
      p2         <= p2_n;
      ties       <= ties_n;
      inv        <= inv_n;
      rc         <= rc_n;
      winner     <= winner_n;
      done       <= done_n;
    end
  end

  always_comb begin
    next_state = state;
    p1_n       = p1;
    p2_n       = p2;
    ties_n     = ties;
    inv_n      = inv;
    rc_n       = rc;
    winner_n   = winner;
    done_n     = 1'b0;
    if (bus.new_match) begin
      // A coincident round event is intentionally dropped here.
      next_state = PLAY;
      p1_n       = '0;
      p2_n       = '0;
      ties_n     = '0;
      inv_n      = '0;
      rc_n       = '0;
      winner_n   = 2'b00;
    end else if (state == PLAY && round_event_c) begin
      case (bus.round_winner)
        2'b01:   begin p1_n   = p1 + ONE;   rc_n = rc + ONE; end
        2'b10:   begin p2_n   = p2 + ONE;   rc_n = rc + ONE; end
        2'b00:   begin ties_n = ties + ONE; rc_n = rc + ONE; end
        default: if (inv != '1) inv_n = inv + ONE;
      endcase
      // A win on the final allowed round takes priority over the draw.
      if (p1_n == WINS) begin
        next_state = DONE;
        winner_n   = 2'b01;
        done_n     = 1'b1;
      end else if (p2_n == WINS) begin
        next_state = DONE;
        winner_n   = 2'b10;
        done_n     = 1'b1;
      end else if (rc_n == MAXR) begin
        next_state = DONE;
        winner_n   = 2'b11;
        done_n     = 1'b1;
      end
    end
  end

  assign bus.p1_score      = p1;
  assign bus.p2_score      = p2;
  assign bus.tie_count     = ties;
  assign bus.invalid_count = inv;
  assign bus.round_count   = rc;
  assign bus.match_over    = (state == DONE);
  assign bus.match_done    = done;
  assign bus.match_winner  = winner;

endmodule

// File: tb/tb_rps_match_scoreboard.sv
// Self-checking bench for rps_match_scoreboard: directed match scenarios plus
// random rounds, compared every cycle against a behavioural match model.
module tb_rps_match_scoreboard;

  localparam int unsigned WINS_TO_TAKE = 3;
  localparam int unsigned MAX_ROUNDS   = 9;
  localparam int unsigned CNT_W        = 4;
  localparam int          SAT          = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  rps_match_scoreboard_if #(.CNT_W(CNT_W)) bus ();

  rps_match_scoreboard #(
    .WINS_TO_TAKE (WINS_TO_TAKE),
    .MAX_ROUNDS   (MAX_ROUNDS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model of the match as the players would see it.
  int m_p1, m_p2, m_tie, m_inv, m_rounds, m_win, m_prev;
  bit m_over, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_p1 = 0; m_p2 = 0; m_tie = 0; m_inv = 0; m_rounds = 0;
    m_win = 0; m_over = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit ev;
    ev = (bus.game_state == 3'b010) && (m_prev != 2);
    m_done = 0;
    if (bus.new_match) begin
      model_clear();
    end else if (!m_over && ev) begin
      case (bus.round_winner)
        2'b01:   begin m_p1++;  m_rounds++; end
        2'b10:   begin m_p2++;  m_rounds++; end
        2'b00:   begin m_tie++; m_rounds++; end
        default: m_inv = (m_inv < SAT) ? m_inv + 1 : SAT;
      endcase
      if (m_p1 == WINS_TO_TAKE)        begin m_over = 1; m_done = 1; m_win = 1; end
      else if (m_p2 == WINS_TO_TAKE)   begin m_over = 1; m_done = 1; m_win = 2; end
      else if (m_rounds == MAX_ROUNDS) begin m_over = 1; m_done = 1; m_win = 3; end
    end
    m_prev = int'(bus.game_state);
  endtask

  task automatic compare_all();
    check("p1_score",      32'(bus.p1_score),      32'(m_p1));
    check("p2_score",      32'(bus.p2_score),      32'(m_p2));
    check("tie_count",     32'(bus.tie_count),     32'(m_tie));
    check("invalid_count", 32'(bus.invalid_count), 32'(m_inv));
    check("round_count",   32'(bus.round_count),   32'(m_rounds));
    check("match_over",    32'(bus.match_over),    32'(m_over));
    check("match_done",    32'(bus.match_done),    32'(m_done));
    check("match_winner",  32'(bus.match_winner),  32'(m_win));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_all();
  endtask

  task automatic play_round(input logic [1:0] w, input int hold, input bit nm_at_entry);
    bus.game_state   = 3'b001;
    bus.round_winner = 2'($urandom);
    bus.new_match    = 1'b0;
    tick();
    bus.game_state   = 3'b010;
    bus.round_winner = w;
    bus.new_match    = nm_at_entry;
    tick();
    bus.new_match    = 1'b0;
    for (int i = 1; i < hold; i++) tick();
    bus.game_state   = 3'b000;
    bus.round_winner = 2'($urandom);
    tick();
  endtask

  task automatic pulse_new_match();
    bus.new_match = 1'b1;
    tick();
    bus.new_match = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.game_state   = 3'b000;
    bus.round_winner = 2'b00;
    bus.new_match    = 1'b0;
    model_clear();
    m_prev = 0;
    #1;
    compare_all();
    #6 reset = 1'b0;

    // Three P1 wins, RESULT held 4 cycles each.
    for (int r = 0; r < 3; r++) begin
      play_round(2'b01, 4, 1'b0);
      check("tp1_p1_score", 32'(bus.p1_score), 32'(r + 1));
    end
    check("tp1_winner", 32'(bus.match_winner), 32'd1);
    check("tp1_rounds", 32'(bus.round_count), 32'd3);

    // Nine ties end in a draw.
    pulse_new_match();
    for (int r = 0; r < 9; r++) play_round(2'b00, 1 + (r % 3), 1'b0);
    check("tp2_ties",   32'(bus.tie_count), 32'd9);
    check("tp2_winner", 32'(bus.match_winner), 32'd3);

    // Win on the final allowed round is a win.
    pulse_new_match();
    for (int r = 0; r < 4; r++) play_round(2'b00, 2, 1'b0);
    play_round(2'b01, 2, 1'b0);
    play_round(2'b10, 2, 1'b0);
    play_round(2'b01, 2, 1'b0);
    play_round(2'b10, 2, 1'b0);
    play_round(2'b01, 2, 1'b0);
    check("tp3_p1_score", 32'(bus.p1_score), 32'd3);
    check("tp3_winner",   32'(bus.match_winner), 32'd1);

    // Invalid rounds saturate and never end the match.
    pulse_new_match();
    for (int r = 0; r < 20; r++) play_round(2'b11, 1, 1'b0);
    check("tp4_invalid", 32'(bus.invalid_count), 32'd15);
    check("tp4_over",    32'(bus.match_over), 32'd0);

    // Rounds in DONE are ignored; new_match drops a coincident round.
    pulse_new_match();
    for (int r = 0; r < 3; r++) play_round(2'b10, 1, 1'b0);
    play_round(2'b01, 2, 1'b0);
    check("tp5_p1_ignored", 32'(bus.p1_score), 32'd0);
    play_round(2'b01, 2, 1'b1);
    check("tp5_cleared_p1", 32'(bus.p1_score), 32'd0);
    check("tp5_cleared_rc", 32'(bus.round_count), 32'd0);

    // Async reset during RESULT, then the held RESULT counts once.
    play_round(2'b10, 1, 1'b0);
    play_round(2'b10, 1, 1'b0);
    bus.game_state   = 3'b001;
    tick();
    bus.game_state   = 3'b010;
    bus.round_winner = 2'b00;
    tick();
    check("tp6_p2_before", 32'(bus.p2_score), 32'd2);
    #3 reset = 1'b1;
    model_clear();
    m_prev = 0;
    #1;
    compare_all();
    tick();
    bus.round_winner = 2'b10;
    #3 reset = 1'b0;
    tick();
    check("tp6_p2_after", 32'(bus.p2_score), 32'd1);
    tick();
    tick();
    bus.game_state = 3'b000;
    tick();

    // Random rounds with occasional new_match, including at RESULT entry.
    for (int r = 0; r < 250; r++) begin
      logic [1:0] w;
      w = 2'($urandom_range(0, 3));
      play_round(w, $urandom_range(1, 4), ($urandom_range(0, 19) == 0));
      if (m_over && ($urandom_range(0, 2) == 0)) pulse_new_match();
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rps_match_scoreboard.md
# rps_match_scoreboard

Downstream stage of the stone-paper-scissors round FSM. Watches the round FSM's `state` and `winner` outputs and detects each completed round. Keeps per-player scores, tie and invalid tallies, and declares a match result under a first-to-N-wins rule with a round cap. Drives the score display and match-status logic.

## Interface
- `WINS_TO_TAKE`, default 3: wins needed to take the match (best-of-5 by default).
- `MAX_ROUNDS`, default 9: counted rounds after which the match ends as a draw if nobody has reached `WINS_TO_TAKE`.
- `CNT_W`, default 4: width of all counters. Legal configurations satisfy 1 ≤ `WINS_TO_TAKE` ≤ `MAX_ROUNDS` ≤ 2^`CNT_W`−1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `game_state` in 3: round FSM state (000 IDLE, 001 EVALUATE, 010 RESULT).
- `round_winner` in 2: round FSM winner (00 tie, 01 P1, 10 P2, 11 invalid).
- `new_match` in 1: synchronous clear of the match; level-sampled each cycle.
- `p1_score` out `CNT_W`: P1 round wins this match.
- `p2_score` out `CNT_W`: P2 round wins this match.
- `tie_count` out `CNT_W`: tied rounds this match.
- `invalid_count` out `CNT_W`: invalid rounds this match; saturates at all-ones.
- `round_count` out `CNT_W`: counted rounds (win or tie) this match.
- `match_over` out 1: level, high while in DONE.
- `match_done` out 1: one-cycle pulse on entry to DONE.
- `match_winner` out 2: 00 in progress, 01 P1, 10 P2, 11 draw.

## Operation
- Internal `prev_state` register, reset to 000, loaded with `game_state` every cycle.
- `round_event` = (`game_state` == 010) && (`prev_state` != 010). It fires once per RESULT entry, however long RESULT is held. `round_winner` is valid in that cycle.
- FSM states are PLAY and DONE. Reset state is PLAY.
- In PLAY, on `round_event`:
  - 01: `p1_score`+1 and `round_count`+1.
  - 10: `p2_score`+1 and `round_count`+1.
  - 00: `tie_count`+1 and `round_count`+1.
  - 11: `invalid_count`+1, saturating. `round_count` is unchanged.
- End checks use the post-update values, in this priority order:
  1. Score == `WINS_TO_TAKE`: go to DONE; `match_winner` is that player.
  2. Else `round_count` == `MAX_ROUNDS`: go to DONE; `match_winner` = 11.
- A win on the final allowed round is a win, not a draw.
- In DONE, `round_event` is ignored: no counter changes. `match_over` stays 1 until `new_match`.
- `new_match` in any state:
  - clears all counters, `match_over`, `match_done` and `match_winner`;
  - enters PLAY;
  - does not clear `prev_state`.
  - `new_match` and `round_event` in the same cycle: `new_match` wins and the event is dropped.
- Reset mid-match behaves like `new_match`, but asynchronously, and also sets `prev_state` to 000. A RESULT present when reset releases is therefore counted once.
- Score counters cannot overflow, because the match ends at `WINS_TO_TAKE`. `round_count` cannot overflow, because it is bounded by `MAX_ROUNDS`.

## Timing
- Reset values: all counters 0, `match_over` 0, `match_done` 0, `match_winner` 00, FSM in PLAY, `prev_state` 000.
- Latency: `game_state` first shows 010 in cycle N. The updated counters, `match_over`, `match_winner` and the `match_done` pulse are visible in cycle N+1.
- `match_done` is high for exactly the one cycle after the deciding event. It is never re-asserted while in DONE.
- `new_match` sampled at the edge ending cycle M gives cleared outputs in cycle M+1.
- Back-to-back rounds are supported. The minimum upstream round is IDLE→EVALUATE→RESULT→IDLE (3 cycles), and each RESULT entry is counted independently.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then three P1-win rounds (`round_winner`=01, RESULT held 4 cycles each). Required: `p1_score` 1, 2, 3, each counted once; after round 3, `match_done` pulses for 1 cycle, `match_over`=1, `match_winner`=01, `round_count`=3.
- Nine tie rounds. Required: `tie_count`=9, `round_count`=9; after the ninth, `match_winner`=11 and `match_over`=1.
- Alternating P1/P2 wins: 4 ties, then P1 2 wins, P2 2 wins, then a P1 win on round 9. Required: `p1_score`=3, `match_winner`=01, not draw.
- Twenty invalid rounds (`round_winner`=11). Required: `invalid_count` saturates at 15, `round_count` stays 0, match stays in PLAY.
- Reach DONE, send one more round, then assert `new_match` on the same cycle as a later RESULT entry. Required: the DONE-state round changes nothing; after `new_match`, all counters are 0, `match_winner`=00, and the coincident round is not counted.
- Assert `reset` while `game_state`=010 with `p2_score`=2. Required: all outputs clear immediately; after release with RESULT still present, `p2_score`=1 (counted once) in the following cycle.
